// File: rtl/regwb_pkg.sv
// Shared types and widths for the register-file writeback queue.
package regwb_pkg;

  localparam int unsigned REG_W     = 5;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned PTR_W_DEF = $clog2(DEPTH_DEF);

  // One pending writeback: destination register and value.
  typedef struct packed {
    logic [REG_W-1:0]  wsel;
    logic [WORD_W-1:0] wdat;
  } wb_entry_t;

  // Queue pointer for the default depth; the top re-derives it from its own DEPTH.
  typedef logic [PTR_W_DEF-1:0] ptr_t;

endpackage

// File: rtl/regwb_lookup.sv
// Youngest-match forwarding search over the pending writeback entries.
module regwb_lookup
  import regwb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  wb_entry_t                  entries [DEPTH],
  input  logic [DEPTH-1:0]           valid,
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [REG_W-1:0]           sel,
  output logic                       hit,
  output logic [WORD_W-1:0]          dat
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Walk oldest to youngest from head so the last match is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit = 1'b0;
    dat = '0;
    idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && (entries[idx].wsel == sel) && (sel != '0)) begin
        hit = 1'b1;
        dat = entries[idx].wdat;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order writeback FIFO feeding the register file's single write port.
// Optional forwarding lookup enabled by defining REGWB_BYPASS_EN.
module regfile_wb_queue
  import regwb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_W-1:0]         in_wsel,
  input  logic [WORD_W-1:0]        in_wdat,
  input  logic                     drain_en,
  output logic                     rf_WEN,
  output logic [REG_W-1:0]         rf_wsel,
  output logic [WORD_W-1:0]        rf_wdat,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [REG_W-1:0]         lk_sel,
  output logic                     lk_hit,
  output logic [WORD_W-1:0]        lk_dat
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             drain;
  logic             store;

  assign full  = (cnt == CNT_W'(DEPTH));
  assign drain = drain_en && (cnt != '0);
  // Register 0 writes complete the handshake but are dropped.
  assign store = in_valid && !full && (in_wsel != '0);

  // Pointer and occupancy tracking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (drain) head <= head + PTR_W'(1);
      if (store) tail <= tail + PTR_W'(1);
      cnt <= cnt + CNT_W'(store) - CNT_W'(drain);
    end
  end

  // Entry storage; contents are don't-care until marked occupied.
  always_ff @(posedge CLK) begin
    if (store) mem[tail] <= '{wsel: in_wsel, wdat: in_wdat};
  end

  assign in_ready = !full;
  assign count    = cnt;
  assign rf_WEN   = drain;
  assign rf_wsel  = drain ? mem[head].wsel : '0;
  assign rf_wdat  = drain ? mem[head].wdat : '0;

`ifdef REGWB_BYPASS_EN
  logic [DEPTH-1:0] valid;

  // Per-entry occupancy for the forwarding search.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid <= '0;
    end else begin
      if (drain) valid[head] <= 1'b0;
      if (store) valid[tail] <= 1'b1;
    end
  end

  regwb_lookup #(.DEPTH(DEPTH)) u_lookup (
    .entries (mem),
    .valid   (valid),
    .head    (head),
    .sel     (lk_sel),
    .hit     (lk_hit),
    .dat     (lk_dat)
  );
`else
  logic unused_lk;
  assign unused_lk = ^lk_sel;
  assign lk_hit    = 1'b0;
  assign lk_dat    = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue against a queue-based reference model.
module tb_regfile_wb_queue;

  localparam int unsigned DEPTH = 4;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_wsel;
  logic [31:0] in_wdat;
  logic        drain_en;
  logic        rf_WEN;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;
  logic [2:0]  count;
  logic [4:0]  lk_sel;
  logic        lk_hit;
  logic [31:0] lk_dat;

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_wsel  (in_wsel),
    .in_wdat  (in_wdat),
    .drain_en (drain_en),
    .rf_WEN   (rf_WEN),
    .rf_wsel  (rf_wsel),
    .rf_wdat  (rf_wdat),
    .count    (count),
    .lk_sel   (lk_sel),
    .lk_hit   (lk_hit),
    .lk_dat   (lk_dat)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef REGWB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int npass = 0;
  int nchecks = 0;
  int nfail = 0;
  bit inited = 1'b0;

  // Reference model: pending entries oldest-first as {wsel, wdat}.
  logic [36:0] q[$];

  // Outputs as observed in the most recent step (for directed checks).
  logic        o_wen, o_ready, o_hit;
  logic [4:0]  o_wsel;
  logic [31:0] o_wdat, o_lkdat;
  logic [2:0]  o_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check every output against the model mid-cycle, then advance the model.
  task automatic step(input logic rst, input logic v, input logic [4:0] ws,
                      input logic [31:0] wd, input logic de, input logic [4:0] ls);
    logic        e_wen, e_ready, e_hit;
    logic [4:0]  e_wsel;
    logic [31:0] e_wdat, e_lkdat;
    int          sz;
    RST = rst; in_valid = v; in_wsel = ws; in_wdat = wd; drain_en = de; lk_sel = ls;
    #4;
    sz      = q.size();
    e_ready = (sz < DEPTH);
    e_wen   = de && (sz != 0);
    e_wsel  = e_wen ? q[0][36:32] : 5'd0;
    e_wdat  = e_wen ? q[0][31:0]  : 32'd0;
    e_hit   = 1'b0;
    e_lkdat = 32'd0;
    if (BYPASS && ls != 5'd0) begin
      for (int i = sz - 1; i >= 0; i--) begin
        if (q[i][36:32] == ls) begin
          e_hit = 1'b1;
          e_lkdat = q[i][31:0];
          break;
        end
      end
    end
    o_wen = rf_WEN; o_wsel = rf_wsel; o_wdat = rf_wdat; o_ready = in_ready;
    o_count = count; o_hit = lk_hit; o_lkdat = lk_dat;
    if (inited) begin
      chk("rf_WEN",   32'(rf_WEN),   32'(e_wen));
      chk("rf_wsel",  32'(rf_wsel),  32'(e_wsel));
      chk("rf_wdat",  rf_wdat,       e_wdat);
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("count",    32'(count),    32'(sz));
      chk("lk_hit",   32'(lk_hit),   32'(e_hit));
      chk("lk_dat",   lk_dat,        e_lkdat);
    end
    @(posedge CLK);
    if (rst) begin
      q.delete();
      inited = 1'b1;
    end else begin
      if (e_wen) void'(q.pop_front());
      if (v && e_ready && ws != 5'd0) q.push_back({ws, wd});
    end
    #1;
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_wsel = '0; in_wdat = '0; drain_en = 1'b0; lk_sel = '0;
    #6;
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Reset with three pending entries discards them.
    step(0, 1, 5'd3, 32'h3, 0, 0);
    step(0, 1, 5'd4, 32'h4, 0, 0);
    step(0, 1, 5'd9, 32'h9, 0, 0);
    chk("pre_rst_count", 32'(count), 32'd3);
    step(1, 0, 0, 0, 1, 5'd3);
    step(0, 0, 0, 0, 1, 5'd3);
    chk("rst_wen",   32'(o_wen),   32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_hit",   32'(o_hit),   32'd0);

    // Single entry: appears on the write port the following cycle.
    step(0, 1, 5'd5, 32'hDEADBEEF, 1, 0);
    chk("lat_first_wen", 32'(o_wen), 32'd0);
    step(0, 0, 0, 0, 1, 0);
    chk("lat_wen",  32'(o_wen),  32'd1);
    chk("lat_wsel", 32'(o_wsel), 32'd5);
    chk("lat_wdat", o_wdat,      32'hDEADBEEF);
    step(0, 0, 0, 0, 1, 0);
    chk("lat_count", 32'(o_count), 32'd0);

    // Fill to full, reject a fifth push, then drain in order.
    for (int i = 1; i <= 4; i++) step(0, 1, 5'(i), 32'(i * 'h11), 0, 0);
    step(0, 1, 5'd6, 32'h66, 0, 0);
    chk("full_ready", 32'(o_ready), 32'd0);
    chk("full_count", 32'(o_count), 32'd4);
    step(0, 0, 0, 0, 1, 0);
    chk("drain1_wsel",  32'(o_wsel),  32'd1);
    chk("drain1_ready", 32'(o_ready), 32'd0);
    step(0, 0, 0, 0, 1, 0);
    chk("drain2_ready", 32'(o_ready), 32'd1);
    chk("drain2_wsel",  32'(o_wsel),  32'd2);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("drain4_wdat", o_wdat, 32'h44);
    step(0, 0, 0, 0, 1, 0);
    chk("drain_empty_wen", 32'(o_wen), 32'd0);

    // Register 0 write is accepted but never stored.
    step(0, 1, 5'd0, 32'h1234, 1, 0);
    chk("r0_ready", 32'(o_ready), 32'd1);
    step(0, 0, 0, 0, 1, 0);
    chk("r0_wen",   32'(o_wen),   32'd0);
    chk("r0_count", 32'(o_count), 32'd0);

    // Forwarding: youngest match wins, misses read zero.
    step(0, 1, 5'd7, 32'hA, 0, 0);
    step(0, 1, 5'd7, 32'hB, 0, 0);
    step(0, 0, 0, 0, 0, 5'd7);
    chk("lk7_hit", 32'(o_hit), BYPASS ? 32'd1 : 32'd0);
    chk("lk7_dat", o_lkdat,    BYPASS ? 32'hB : 32'd0);
    step(0, 0, 0, 0, 0, 5'd8);
    chk("lk8_hit", 32'(o_hit), 32'd0);
    chk("lk8_dat", o_lkdat,    32'd0);
    step(0, 0, 0, 0, 1, 5'd7);
    chk("fwd_drain_a", o_wdat, 32'hA);
    step(0, 0, 0, 0, 1, 5'd7);
    chk("fwd_drain_b", o_wdat, 32'hB);
    step(0, 0, 0, 0, 1, 5'd7);

    // Continuous enqueue and drain with random destinations.
    for (int i = 0; i < 40; i++)
      step(0, 1, 5'($urandom_range(31, 1)), $urandom, 1, 5'($urandom_range(31, 0)));
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);

    // Random traffic exercising full, empty and pointer wrap.
    for (int i = 0; i < 300; i++)
      step(0, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), $urandom,
           1'($urandom_range(3, 0) != 0 ? ($urandom_range(1, 0)) : 0),
           5'($urandom_range(7, 0)));
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0);
    chk("final_count", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule
